// File: rtl/m_serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry flop produce an
// N-bit sum over WIDTH cycles behind a start/busy/done handshake.
module m_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_start,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    input  logic             w_cin,
    output logic             w_busy,
    output logic             w_done,
    output logic [WIDTH-1:0] w_s,
    output logic             w_cout,
    output logic             w_ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;
    logic             w_load;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_sum_next;

    assign w_fa_s     = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_fa_c     = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_load     = w_start && (r_state != S_RUN);
    // Widened concat keeps the right-shift legal when WIDTH is 1.
    assign w_sum_ext  = {w_fa_s, r_sum};
    assign w_sum_next = w_sum_ext[WIDTH:1];

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_RUN;
            S_RUN:   if (w_last)  w_state_next = S_DONE;
            S_DONE:  if (w_start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_opa   <= w_a;
            r_opb   <= w_b;
            r_carry <= w_cin;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_sum   <= w_sum_next;
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + CW'(1);
            // Carry flop still holds the carry into the MSB on the last bit.
            if (w_last) begin
                r_s    <= w_sum_next;
                r_cout <= w_fa_c;
                r_ovf  <= r_carry ^ w_fa_c;
            end
        end
    end

    assign w_busy = (r_state == S_RUN);
    assign w_done = (r_state == S_DONE);
    assign w_s    = r_s;
    assign w_cout = r_cout;
    assign w_ovf  = r_ovf;

endmodule

// File: tb/tb_m_serial_adder.sv
// Directed self-checking bench for m_serial_adder at WIDTH=8.
module tb_m_serial_adder;

    logic       w_clk = 1'b0;
    logic       w_rst_n;
    logic       w_start;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_cin;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_s;
    logic       w_cout;
    logic       w_ovf;

    int n_pass  = 0;
    int n_total = 0;

    m_serial_adder #(.WIDTH(8)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_start (w_start),
        .w_a     (w_a),
        .w_b     (w_b),
        .w_cin   (w_cin),
        .w_busy  (w_busy),
        .w_done  (w_done),
        .w_s     (w_s),
        .w_cout  (w_cout),
        .w_ovf   (w_ovf)
    );

    always #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic busy, input logic done,
                           input logic [7:0] s, input logic cout, input logic ovf);
        chk({tag, "/busy"}, {31'd0, w_busy}, {31'd0, busy});
        chk({tag, "/done"}, {31'd0, w_done}, {31'd0, done});
        chk({tag, "/s"},    {24'd0, w_s},    {24'd0, s});
        chk({tag, "/cout"}, {31'd0, w_cout}, {31'd0, cout});
        chk({tag, "/ovf"},  {31'd0, w_ovf},  {31'd0, ovf});
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin);
        w_a = a;
        w_b = b;
        w_cin = cin;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        w_a = 8'h5A;
        w_b = 8'hC3;
        w_cin = 1'b1;
    endtask

    // Launch, check busy through the run, then check the result at k+8.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] old_s;
        logic       old_c;
        logic       old_o;
        old_s = w_s;
        old_c = w_cout;
        old_o = w_ovf;
        launch(a, b, cin);
        chk_out({tag, "@k"}, 1'b1, 1'b0, old_s, old_c, old_o);
        for (int i = 1; i < 8; i++) step();
        chk_out({tag, "@k+7"}, 1'b1, 1'b0, old_s, old_c, old_o);
        step();
        chk_out({tag, "@k+8"}, 1'b0, 1'b1, es, ec, eo);
    endtask

    initial begin
        w_rst_n = 1'b0;
        w_start = 1'b1;
        w_a = 8'hFF;
        w_b = 8'hFF;
        w_cin = 1'b1;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        w_rst_n = 1'b1;
        w_start = 1'b0;
        step();
        chk_out("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        run_add("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        step();
        step();
        chk_out("done_hold", 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);

        run_add("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_add("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_add("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Start pulsed during RUN must be ignored.
        launch(8'h12, 8'h34, 1'b0);
        step();
        step();
        w_a = 8'hFF;
        w_b = 8'hFF;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk_out("ign@k+3", 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) step();
        chk_out("ign@k+7", 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        step();
        chk_out("ign@k+8", 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);

        // Relaunch directly from the DONE cycle.
        run_add("relaunch", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Reset in the middle of a run.
        launch(8'h33, 8'h44, 1'b0);
        step();
        step();
        step();
        w_rst_n = 1'b0;
        step();
        chk_out("midrst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        w_rst_n = 1'b1;
        step();
        chk_out("post_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_add("aa+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_serial_adder.md
# m_serial_adder

Bit-serial ripple adder that computes an N-bit sum one bit per clock using a single full-adder slice and a registered carry. It sits directly upstream of the combinational full-adder stage: it owns the operand shift registers, the carry flip-flop and the sequencing, and feeds one bit pair plus carry per cycle into the FA slice. A start/busy/done handshake lets a controller launch an addition and collect the registered sum, carry-out and signed overflow.

## Interface

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- w_clk  input  1  single clock; all state updates on its rising edge.
- w_rst_n  input  1  reset, synchronous, active-low.
- w_start  input  1  launch request; sampled only in IDLE or DONE.
- w_a  input  WIDTH  operand A; captured on the accepted-start edge only.
- w_b  input  WIDTH  operand B; captured on the accepted-start edge only.
- w_cin  input  1  carry-in; captured on the accepted-start edge only.
- w_busy  output  1  high while in RUN.
- w_done  output  1  high while in DONE; result outputs valid.
- w_s  output  WIDTH  registered sum.
- w_cout  output  1  registered carry-out of the MSB.
- w_ovf  output  1  registered two's-complement overflow.

## Operation

- States: IDLE, RUN, DONE. Encoding is free. Only the outputs are observable.
- IDLE: w_start=1 loads the operand shift registers with w_a and w_b, loads the carry flop with w_cin, clears the bit counter and the sum shift register, and moves to RUN. w_start=0 keeps the block in IDLE.
- RUN, once per cycle:
  - The FA slice takes opA[0], opB[0] and the carry flop.
  - Its sum bit shifts into the MSB of the sum shift register, which shifts right.
  - Both operand registers shift right.
  - The carry flop takes the FA carry-out.
  - The counter increments.
- RUN, last bit (counter == WIDTH-1):
  - w_s takes the final sum shift-register contents, including the current bit.
  - w_cout takes the FA carry-out.
  - w_ovf takes the carry into the MSB (the carry flop before this step) XOR the FA carry-out.
  - The state moves to DONE.
- w_start is ignored throughout RUN. Input operand changes during RUN have no effect.
- DONE: w_done=1 and the results are held. w_start=1 relaunches exactly as from IDLE: new operands are captured, the state goes to RUN, and w_done drops on the next edge. The block stays in DONE indefinitely without w_start.
- w_s, w_cout and w_ovf change only when entering DONE or on reset. They hold the previous result through IDLE and RUN.
- Arithmetic: {w_cout, w_s} = w_a + w_b + w_cin, unsigned and exact. w_ovf = 1 iff the signed interpretation of the result overflowed.
- WIDTH=1: RUN lasts one cycle. w_ovf = w_cin XOR w_cout.

## Timing

- Reset (w_rst_n=0 at a rising edge): state IDLE, and w_busy, w_done, w_s, w_cout and w_ovf are all 0. All internal registers are cleared.
- Reset has priority over w_start and aborts RUN or DONE at any point. There is no partial result.
- Outputs are registered only, with no combinational input-to-output paths.
- Latency: when w_start is accepted at edge k, w_busy=1 after edge k. Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- w_busy falls, and w_done, w_s, w_cout and w_ovf become valid, after edge k+WIDTH. That is exactly WIDTH cycles after the accept edge.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles, since the DONE cycle is the earliest relaunch point.
- w_busy and w_done are never high together.

## Test plan

All scenarios use WIDTH=8.

- Reset: hold w_rst_n=0 for 2 edges with w_start=1 -> busy=0, done=0, s=8'h00, cout=0, ovf=0, and no launch occurs.
- Basic add: a=8'h0F, b=8'h01, cin=0, start pulsed at edge k -> busy high during edges k+1..k+8; after edge k+8, done=1, s=8'h10, cout=0, ovf=0.
- Carry and overflow, one result per case:
  - a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80, cin=0 -> s=8'h00, cout=1, ovf=1.
  - a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1, ovf=0.
- Ignored start: launch a=8'h12, b=8'h34, then pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> result s=8'h46, cout=0, still delivered at k+8.
- Relaunch from DONE: assert start in the DONE cycle with a=8'h01, b=8'h01 -> done=0 and busy=1 after the next edge; the old result is held until the new DONE; the new result is s=8'h02, 8 cycles later.
- Mid-run reset: w_rst_n=0 at RUN cycle 4 -> all outputs 0 after that edge. A following launch of a=8'hAA, b=8'h55, cin=1 -> s=8'h00, cout=1, ovf=0 after 8 cycles.
